// File: rtl/alsu_checker.sv
// Self-checking monitor for the ALSU: a two-stage reference model runs alongside the
// observed DUT, and every clock in CHECK its out/leds are compared against the model.
module alsu_checker #(
  parameter string       INPUT_PRIORITY = "A",
  parameter string       FULL_ADDER     = "ON",
  parameter int unsigned CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       A,
  input  logic [2:0]       B,
  input  logic [2:0]       opcode,
  input  logic             cin,
  input  logic             serial_in,
  input  logic             direction,
  input  logic             red_op_A,
  input  logic             red_op_B,
  input  logic             bypass_A,
  input  logic             bypass_B,
  input  logic [5:0]       out,
  input  logic [15:0]      leds,
  output logic             mismatch,
  output logic             sticky_fail,
  output logic [CNT_W-1:0] check_count,
  output logic [CNT_W-1:0] error_count,
  output logic [2:0]       first_fail_opcode,
  output logic [5:0]       exp_out,
  output logic [15:0]      exp_leds
);

  localparam bit PRIO_A = (INPUT_PRIORITY == "A");
  localparam bit FA_ON  = (FULL_ADDER == "ON");

  typedef enum logic [1:0] {IDLE, FILL, CHECK} state_t;

  state_t      state, state_nx;
  logic [2:0]  a_q, b_q, op_q, op2_q;
  logic        cin_q, si_q, dir_q, ra_q, rb_q, ba_q, bb_q;
  logic        invalid;
  logic [2:0]  red_src;
  logic [5:0]  model_out;
  logic [15:0] model_leds;
  logic        do_cmp, fail;

  // Stage 1: capture every observed input each clock, independent of en.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= '0;
      cin_q <= 1'b0;
      si_q  <= 1'b0;
      dir_q <= 1'b0;
      ra_q  <= 1'b0;
      rb_q  <= 1'b0;
      ba_q  <= 1'b0;
      bb_q  <= 1'b0;
    end else begin
      a_q   <= A;
      b_q   <= B;
      op_q  <= opcode;
      cin_q <= cin;
      si_q  <= serial_in;
      dir_q <= direction;
      ra_q  <= red_op_A;
      rb_q  <= red_op_B;
      ba_q  <= bypass_A;
      bb_q  <= bypass_B;
    end
  end

  always_comb begin
    invalid    = (op_q == 3'd6) || (op_q == 3'd7) || ((ra_q || rb_q) && (op_q > 3'd1));
    // Reduction operand: A alone, B alone, or the priority operand when both are requested.
    red_src    = (ra_q && (!rb_q || PRIO_A)) ? a_q : b_q;
    model_out  = '0;
    model_leds = '0;
    if (ba_q && bb_q) begin
      model_out = PRIO_A ? {3'b000, a_q} : {3'b000, b_q};
    end else if (ba_q) begin
      model_out = {3'b000, a_q};
    end else if (bb_q) begin
      model_out = {3'b000, b_q};
    end else if (invalid) begin
      model_out  = '0;
      model_leds = ~exp_leds;
    end else begin
      case (op_q)
        3'd0: model_out = (ra_q || rb_q) ? {5'b00000, &red_src} : {3'b000, a_q & b_q};
        3'd1: model_out = (ra_q || rb_q) ? {5'b00000, ^red_src} : {3'b000, a_q ^ b_q};
        3'd2: model_out = {3'b000, a_q} + {3'b000, b_q} + {5'b00000, cin_q & FA_ON};
        3'd3: model_out = {3'b000, a_q} * {3'b000, b_q};
        3'd4: model_out = dir_q ? {exp_out[4:0], si_q} : {si_q, exp_out[5:1]};
        3'd5: model_out = dir_q ? {exp_out[4:0], exp_out[5]} : {exp_out[0], exp_out[5:1]};
        default: model_out = '0;
      endcase
    end
  end

  // Stage 2: model result, plus the opcode that produced it for failure capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exp_out  <= '0;
      exp_leds <= '0;
      op2_q    <= '0;
    end else begin
      exp_out  <= model_out;
      exp_leds <= model_leds;
      op2_q    <= op_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // The enabling edge and the FILL edge are the two non-comparing clocks that
  // let post-enable stimulus reach stage 2 before the first compare.
  always_comb begin
    state_nx = state;
    do_cmp   = (state == CHECK);
    case (state)
      IDLE:    if (en) state_nx = FILL;
      FILL:    state_nx = en ? CHECK : IDLE;
      CHECK:   if (!en) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign fail = (out != exp_out) || (leds != exp_leds);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mismatch          <= 1'b0;
      sticky_fail       <= 1'b0;
      check_count       <= '0;
      error_count       <= '0;
      first_fail_opcode <= '0;
    end else begin
      mismatch <= 1'b0;
      if (do_cmp) begin
        if (check_count != '1) check_count <= check_count + 1'b1;
        if (fail) begin
          mismatch <= 1'b1;
          if (error_count != '1) error_count <= error_count + 1'b1;
          if (!sticky_fail) begin
            sticky_fail       <= 1'b1;
            first_fail_opcode <= op2_q;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_alsu_checker.sv
// Bench for alsu_checker: emulates a correct ALSU (with optional corrupted outputs) from a
// behavioural model and scoreboards every checker output on each falling edge.
module tb_alsu_checker;
  localparam int CW  = 5;
  localparam int SAT = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst, en;
  logic [2:0]    A, B, opcode;
  logic          cin, serial_in, direction, red_op_A, red_op_B, bypass_A, bypass_B;
  logic [5:0]    out;
  logic [15:0]   leds;
  logic          mismatch, sticky_fail;
  logic [CW-1:0] check_count, error_count;
  logic [2:0]    first_fail_opcode;
  logic [5:0]    exp_out;
  logic [15:0]   exp_leds;

  alsu_checker #(.INPUT_PRIORITY("A"), .FULL_ADDER("ON"), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .en(en), .A(A), .B(B), .opcode(opcode), .cin(cin),
    .serial_in(serial_in), .direction(direction), .red_op_A(red_op_A), .red_op_B(red_op_B),
    .bypass_A(bypass_A), .bypass_B(bypass_B), .out(out), .leds(leds),
    .mismatch(mismatch), .sticky_fail(sticky_fail), .check_count(check_count),
    .error_count(error_count), .first_fail_opcode(first_fail_opcode),
    .exp_out(exp_out), .exp_leds(exp_leds)
  );

  always #5 clk = ~clk;

  typedef struct { int a, b, op; bit cin, si, dir, ra, rb, ba, bb; } stim_t;
  typedef struct { int cyc; bit mm, sticky; int chk, err, ffo, eo, el; } exp_t;

  exp_t sb[$];
  int   passed = 0, total = 0, cyc = 0;

  // Model history: r1 = result of last cycle's inputs, r2 = the one before.
  int r1_out, r1_leds, r2_out, r2_leds, r1_op, r2_op;
  int run, m_chk, m_err, m_ffo;
  bit m_sticky;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int expv);
    total++;
    if (act == expv) passed++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
  endtask

  function automatic stim_t mk(input int a, input int b, input int op,
                               input bit cin = 0, input bit si = 0, input bit dir = 0,
                               input bit ra = 0, input bit rb = 0, input bit ba = 0,
                               input bit bb = 0);
    stim_t s;
    s.a = a; s.b = b; s.op = op; s.cin = cin; s.si = si; s.dir = dir;
    s.ra = ra; s.rb = rb; s.ba = ba; s.bb = bb;
    return s;
  endfunction

  function automatic stim_t rnd_stim();
    return mk($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
              $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
  endfunction

  // Behavioural ALSU result for one input set, given the previous result and LEDs.
  function automatic void ref_alsu(input stim_t s, input int pout, input int pleds,
                                   output int o, output int l);
    bit bad;
    int src;
    bad = (s.op >= 6) || ((s.ra || s.rb) && s.op > 1);
    src = s.ra ? s.a : s.b;
    l = 0;
    o = 0;
    if (s.ba) o = s.a;
    else if (s.bb) o = s.b;
    else if (bad) l = pleds ^ 'hFFFF;
    else begin
      case (s.op)
        0: o = (s.ra || s.rb) ? ((src == 7) ? 1 : 0) : (s.a & s.b);
        1: o = (s.ra || s.rb) ? ($countones(src) % 2) : (s.a ^ s.b);
        2: o = s.a + s.b + int'(s.cin);
        3: o = s.a * s.b;
        4: o = s.dir ? (pout * 2 + int'(s.si)) % 64 : int'(s.si) * 32 + pout / 2;
        default: o = s.dir ? (pout * 2) % 64 + pout / 32 : (pout % 2) * 32 + pout / 2;
      endcase
    end
  endfunction

  task automatic init_model();
    r1_out = 0; r1_leds = 0; r2_out = 0; r2_leds = 0; r1_op = 0; r2_op = 0;
    run = 0; m_chk = 0; m_err = 0; m_ffo = 0; m_sticky = 0;
  endtask

  // Drive one cycle (called just after a rising edge) and predict the state after the next edge.
  task automatic step(input stim_t s, input bit en_v = 1, input bit inj = 0);
    int   ro, rl;
    exp_t e;
    en = en_v;
    A = 3'(s.a); B = 3'(s.b); opcode = 3'(s.op); cin = s.cin; serial_in = s.si;
    direction = s.dir; red_op_A = s.ra; red_op_B = s.rb; bypass_A = s.ba; bypass_B = s.bb;
    out  = 6'(inj ? (r2_out ^ 63) : r2_out);
    leds = 16'(r2_leds);
    ref_alsu(s, r1_out, r1_leds, ro, rl);
    e.cyc = cyc + 1;
    e.mm  = 0;
    if (run >= 2) begin
      m_chk = (m_chk == SAT) ? SAT : m_chk + 1;
      if (inj) begin
        e.mm  = 1;
        m_err = (m_err == SAT) ? SAT : m_err + 1;
        if (!m_sticky) begin
          m_sticky = 1;
          m_ffo    = r2_op;
        end
      end
    end
    run = en_v ? run + 1 : 0;
    e.sticky = m_sticky; e.chk = m_chk; e.err = m_err; e.ffo = m_ffo;
    e.eo = r1_out; e.el = r1_leds;
    sb.push_back(e);
    r2_out = r1_out; r2_leds = r1_leds; r2_op = r1_op;
    r1_out = ro;     r1_leds = rl;      r1_op = s.op;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    exp_t e;
    en = 0;
    e.cyc = cyc + 1; e.mm = 0; e.sticky = 0; e.chk = 0; e.err = 0; e.ffo = 0; e.eo = 0; e.el = 0;
    sb.push_back(e);
    init_model();
    @(negedge clk);
    #1 rst = 0;
    #1;
    chk("async_rst_check_count", int'(check_count), 0);
    chk("async_rst_sticky", int'(sticky_fail), 0);
    chk("async_rst_exp_out", int'(exp_out), 0);
    chk("async_rst_exp_leds", int'(exp_leds), 0);
    @(posedge clk);
    #1 rst = 1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        chk("stale_entry_cycle", sb[0].cyc, cyc);
        void'(sb.pop_front());
      end
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        e = sb.pop_front();
        chk("mismatch", int'(mismatch), int'(e.mm));
        chk("sticky_fail", int'(sticky_fail), int'(e.sticky));
        chk("check_count", int'(check_count), e.chk);
        chk("error_count", int'(error_count), e.err);
        chk("first_fail_opcode", int'(first_fail_opcode), e.ffo);
        chk("exp_out", int'(exp_out), e.eo);
        chk("exp_leds", int'(exp_leds), e.el);
      end
    end
  end

  initial begin : driver
    rst = 1; en = 0; A = 0; B = 0; opcode = 0; cin = 0; serial_in = 0; direction = 0;
    red_op_A = 0; red_op_B = 0; bypass_A = 0; bypass_B = 0; out = 0; leds = 0;
    #1 rst = 0;
    #1;
    chk("reset_check_count", int'(check_count), 0);
    chk("reset_error_count", int'(error_count), 0);
    chk("reset_mismatch", int'(mismatch), 0);
    chk("reset_exp_out", int'(exp_out), 0);
    @(posedge clk);
    #1 rst = 1;
    init_model();

    repeat (10) step(mk(5, 7, 2, 1));
    chk("add_check_count", int'(check_count), 8);
    chk("add_exp_out", int'(exp_out), 13);
    chk("add_error_count", int'(error_count), 0);
    chk("add_sticky", int'(sticky_fail), 0);

    repeat (3) step(mk(5, 7, 3));
    repeat (3) step(mk(5, 7, 0, 0, 0, 0, 1));
    repeat (3) step(mk(5, 7, 1, 0, 0, 0, 1));
    repeat (4) step(mk(5, 7, 6));
    repeat (3) step(mk(5, 7, 6, 0, 0, 0, 0, 0, 1));
    step(mk(5, 7, 6));
    repeat (3) step(mk(5, 7, 4, 0, 1, 1));
    repeat (2) step(mk(5, 7, 5, 0, 0, 0));

    repeat (3) step(mk(5, 7, 2, 1));
    step(mk(5, 7, 2, 1), 1, 1);
    repeat (3) step(mk(5, 7, 2, 1));
    chk("inj1_error_count", int'(error_count), 1);
    chk("inj1_first_fail_opcode", int'(first_fail_opcode), 2);
    repeat (3) step(mk(3, 6, 3));
    step(mk(3, 6, 3), 1, 1);
    repeat (2) step(mk(3, 6, 3));
    chk("inj2_error_count", int'(error_count), 2);
    chk("inj2_first_fail_opcode", int'(first_fail_opcode), 2);

    do_reset();
    repeat (6) step(mk(5, 7, 2, 1));

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 149) == 0) do_reset();
      else step(rnd_stim(), $urandom_range(0, 19) != 0, $urandom_range(0, 4) == 0);
    end
    en = 0;

    for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk);
    #1;
    chk("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/alsu_checker.md
Name: alsu_checker

Overview:
- Receive-side counterpart of the ALSU stimulus path: a synthesizable monitor that observes every ALSU input and the ALSU's `out`/`leds` outputs.
- Internally it runs a cycle-accurate reference model of the ALSU and compares the DUT outputs against it on every clock.
- It flags mismatches and keeps pass/fail statistics, so FPGA bring-up and regressions are self-checking without a simulator scoreboard.

Parameters:
- INPUT_PRIORITY, "A", operand chosen when both red_op or both bypass bits are set ("A" or "B"); must match the DUT.
- FULL_ADDER, "ON", "ON" adds cin in opcode 2, "OFF" ignores cin; must match the DUT.
- CNT_W, 16, width of the check and error counters.

Ports:
- clk  input  1  clock shared with the ALSU
- rst  input  1  asynchronous, active-low reset
- en  input  1  checking enable; hold low while the ALSU is in reset
- A  input  3  observed ALSU operand A
- B  input  3  observed ALSU operand B
- opcode  input  3  observed ALSU opcode
- cin, serial_in, direction  input  1 each  observed ALSU controls
- red_op_A, red_op_B, bypass_A, bypass_B  input  1 each  observed ALSU controls
- out  input  6  observed ALSU result
- leds  input  16  observed ALSU LEDs
- mismatch  output  1  one-cycle pulse on any compare failure
- sticky_fail  output  1  set on first mismatch, cleared only by reset
- check_count  output  CNT_W  number of compares performed, saturating
- error_count  output  CNT_W  number of failed compares, saturating
- first_fail_opcode  output  3  stage-2 opcode at the first mismatch
- exp_out  output  6  model result, for waveform debug
- exp_leds  output  16  model LEDs, for waveform debug

Behaviour:
- Reset (rst=0, async): all outputs 0, model pipeline 0, FSM to IDLE.
- Model stage 1: registers all eleven ALSU inputs every clock, regardless of en.
- Model stage 2: computes exp_out/exp_leds from stage-1 values. Total latency is 2 clocks, input to compare, matching the DUT.
- invalid = (opcode==6 or 7) or ((red_op_A|red_op_B) and opcode not in {0,1}).
- exp_out priority, highest first:
  - bypass_A&bypass_B -> A if INPUT_PRIORITY=="A", else B
  - bypass_A -> A
  - bypass_B -> B
  - invalid -> 0
  - op0 (AND): red_op_A&red_op_B -> reduction-AND of the priority operand; red_op_A -> &A; red_op_B -> &B; else A&B (zero-extended)
  - op1 (XOR): same structure with reduction-XOR / A^B
  - op2 -> A+B+(FULL_ADDER=="ON" ? cin : 0), zero-extended to 6 bits
  - op3 -> A*B (6 bits, no overflow possible)
  - op4 shift: direction=1 -> {exp_out[4:0],serial_in}; direction=0 -> {serial_in,exp_out[5:1]}
  - op5 rotate: direction=1 -> {exp_out[4:0],exp_out[5]}; direction=0 -> {exp_out[0],exp_out[5:1]}
- exp_leds: invalid and no bypass -> ~exp_leds (blink); otherwise 16'h0000.
- FSM:
  - IDLE: en=0; no compares; counters held.
  - IDLE->FILL on en=1.
  - FILL: 2 clocks so the pipeline holds post-enable stimulus, then ->CHECK.
  - CHECK: each clock compare (out!=exp_out)|(leds!=exp_leds).
  - Any state -> IDLE on en=0. Re-enable always passes through FILL again.
- On compare:
  - check_count increments, saturating at all-ones.
  - On fail: mismatch=1 for that cycle; error_count increments, saturating.
  - On the first fail only: sticky_fail=1 and first_fail_opcode captured.
- Simultaneous en fall and failing compare in CHECK: the compare still counts, since it is registered on that edge.
- Counters freeze once saturated; mismatch still pulses.

Test Plan:
- A=5, B=7, opcode=2, cin=1, no bypass/red_op, en=1 for 10 cycles -> exp_out=13; check_count=8 (2 FILL cycles); error_count=0; sticky_fail=0.
- A=5, B=7, opcode=3 -> exp_out=35; no mismatch. Then opcode=0 with red_op_A=1 -> exp_out=0; opcode=1 with red_op_A=1 -> exp_out=0 (5 has even parity).
- Hold opcode=6 for 4 cycles -> exp_leds alternates FFFF, 0000, FFFF, 0000 and exp_out=0. Set bypass_A=1 -> exp_out=5, exp_leds=0.
- opcode=4, direction=1, serial_in=1 starting from exp_out=0 -> 01, 03, 07 over 3 cycles. opcode=5, direction=0 from 07 -> 23, 31.
- Force DUT out to 6'h3F for one cycle while opcode=2 -> one-cycle mismatch; error_count=1; sticky_fail=1; first_fail_opcode=2. A second forced error leaves first_fail_opcode unchanged and error_count=2.
- Assert rst=0 mid-CHECK, asynchronously between edges -> all outputs 0 immediately. Release with en=1 -> 2 FILL cycles before compares resume.
